// File: rtl/concat_sched_pkg.sv
// Shared constants and FSM encoding for the nibble-pair scheduler.
package concat_sched_pkg;

    localparam int unsigned NW_DEF    = 4;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the caller owns and updates last_grant.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       any_req
);

    // Lone requester wins; on a tie the one not served last wins.
    always_comb begin
        any_req = |req;
        grant   = (req == 2'b11) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/concat_pair_scheduler.sv
// Shares a nibble-concatenation datapath between two requesters, one byte at a time.
module concat_pair_scheduler
    import concat_sched_pkg::*;
#(
    parameter int unsigned NW    = NW_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [NW-1:0]     req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [NW-1:0]     req1_data,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [2*NW-1:0]   out_data,
    output logic              out_src,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  byte_cnt
);

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [NW-1:0]       hi_q, hi_d;
    logic                owner_q, owner_d;
    logic                out_valid_q, out_valid_d;
    logic [2*NW-1:0]     out_data_q, out_data_d;
    logic                out_src_q, out_src_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic grant;
    logic any_req;
    logic xfer0;
    logic xfer1;

    rr_arbiter2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant),
        .any_req    (any_req)
    );

    // Ready: arbitration winner in IDLE, locked owner in LOW, nobody in OUT.
    always_comb begin
        req0_ready = ((state_q == ST_IDLE) && any_req && !grant) ||
                     ((state_q == ST_LOW) && !owner_q);
        req1_ready = ((state_q == ST_IDLE) && any_req && grant) ||
                     ((state_q == ST_LOW) && owner_q);
        xfer0      = req0_valid && req0_ready;
        xfer1      = req1_valid && req1_ready;
    end

    // Next-state and datapath updates for hi capture, byte assembly and delivery.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        hi_d         = hi_q;
        owner_d      = owner_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer0 || xfer1) begin
                    hi_d         = xfer1 ? req1_data : req0_data;
                    owner_d      = xfer1;
                    last_grant_d = xfer1;
                    state_d      = ST_LOW;
                end
            end
            ST_LOW: begin
                if (owner_q ? xfer1 : xfer0) begin
                    out_data_d  = {hi_q, (owner_q ? req1_data : req0_data)};
                    out_src_d   = owner_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; req0 gets first priority out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            hi_q         <= '0;
            owner_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            hi_q         <= hi_d;
            owner_q      <= owner_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign byte_cnt  = cnt_q;

endmodule
